ball_motion_sequencer: RTL and testbench
========================================

# ball_motion_sequencer

Per-frame motion controller that drives the VGA ball peripheral's write port, directly upstream of it. On each frame tick it advances the ball position by a programmable speed, bounces off the 640x480 screen edges (radius-aware), and then issues a fixed five-write burst on the peripheral's register bus: radius, x low, x high, y low, y high. This replaces software polling for simple bouncing-ball demos.

## Interface
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in pixels
- X_INIT, 30, reset x position
- Y_INIT, 30, reset y position
- R_INIT, 16, reset effective radius

- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse once per frame (start of vertical blank)
- run  in  1  1 = advance position on tick; 0 = hold position but still emit writes
- speed_x  in  4  unsigned x step per frame
- speed_y  in  4  unsigned y step per frame
- radius  in  8  requested radius; sampled on an accepted tick
- chipselect  out  1  peripheral select, high only during write cycles
- write  out  1  write strobe, identical to chipselect
- address  out  3  peripheral register address
- writedata  out  8  peripheral write data
- busy  out  1  high from the update cycle through the last write
- overrun  out  1  sticky: a tick arrived while busy; cleared only by reset
- pos_x  out  10  current x position
- pos_y  out  10  current y position

## Operation
- Reset is asynchronous and active-high. All outputs and state take their reset values immediately, without waiting for a clock edge:
  - state IDLE;
  - chipselect, write, busy and overrun all 0;
  - address 0 and writedata 0;
  - pos_x = X_INIT and pos_y = Y_INIT;
  - dir_x = dir_y = + (increasing);
  - effective radius r = R_INIT.
- States: IDLE -> UPDATE -> WR_R -> WR_XL -> WR_XH -> WR_YL -> WR_YH -> IDLE.
- IDLE with frame_tick=1:
  - accept the tick and move to UPDATE;
  - latch r = min(radius, V_MAX/2 - 1), i.e. radius saturates at 239.
- UPDATE (one cycle), when run=1, per axis:
  - next value n = pos ± speed, using sign-extended 11-bit arithmetic and the current direction;
  - upper bound hi = MAX-1-r.
  - Clamp rules, checked in this order:
    - n >= hi: pos = hi, dir = -;
    - else n <= r: pos = r, dir = +;
    - else pos = n.
  - The clamp applies regardless of direction, so a ball left out of range by a radius change is pulled back inside on the next tick.
- UPDATE with run=0: position and direction are unchanged.
- Write states, one cycle each, with chipselect = write = 1:
  - WR_R: address 0, writedata = r;
  - WR_XL: address 3, writedata = {3'b0, pos_x[4:0]};
  - WR_XH: address 4, writedata = {3'b0, pos_x[9:5]};
  - WR_YL: address 5, writedata = {3'b0, pos_y[4:0]};
  - WR_YH: address 6, writedata = {3'b0, pos_y[9:5]}.
  - The low half is always written before the high half, because the peripheral commits the coordinate on the high write.
- Outside the write states: chipselect = write = 0, and address and writedata hold their last values.
- frame_tick while not in IDLE:
  - the tick is dropped and overrun is set to 1;
  - the burst in progress is neither restarted nor extended.
- A tick that coincides with the WR_YH cycle is also dropped, because the state is not yet IDLE.

## Timing
- Tick sampled high in IDLE at edge T:
  - cycle T+1 is UPDATE, with busy=1;
  - cycles T+2..T+6 carry the writes in the order 0, 3, 4, 5, 6;
  - busy falls and the state returns to IDLE after cycle T+6.
- The earliest next accepted tick is at cycle T+7.
- pos_x and pos_y change only at the end of UPDATE, and are stable throughout the write cycles.
- Reset asserted mid-burst drops write on the same cycle; the remaining writes are abandoned.
- There is no backpressure: the peripheral accepts every write in one cycle.

## Test plan
- Reset, then observe 10 cycles with no tick:
  - all outputs stay at reset values;
  - pos = (30,30);
  - no write pulses.
- From reset: run=1, speed 2/3, radius 16, one tick:
  - writes (addr,data) = (0,16), (3,0), (4,1), (5,1), (6,1) on cycles T+2..T+6;
  - pos = (32,33).
- Right bounce: pos_x=620, dir +, speed_x=5, r=16, tick:
  - pos_x = 623 and dir -;
  - next tick gives pos_x = 618;
  - XL/XH data = 15/19 (623 = 19*32+15).
- Tick at T+3 during a burst:
  - exactly 5 writes occur;
  - overrun = 1 and stays 1 until reset.
- run=0 with radius changed to 255:
  - writes (0,239) and the unchanged x/y halves;
  - on a later run=1 tick, pos_y is clamped into [239,240].
- Assert reset at cycle T+4 of a burst:
  - write drops immediately and no further writes occur;
  - pos returns to (30,30).

Source files
------------

// File: rtl/ball_motion_sequencer_if.sv
// Register write bus between the motion sequencer and the VGA ball peripheral.
interface ball_motion_sequencer_if;
  logic       chipselect;
  logic       write;
  logic [2:0] address;
  logic [7:0] writedata;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata
  );

  modport slave (
    input chipselect,
    input write,
    input address,
    input writedata
  );
endinterface

// File: rtl/ball_motion_sequencer.sv
// Per-frame ball motion controller: steps the position on each frame tick,
// bounces off the radius-inset screen edges, then writes radius and the
// split x/y coordinates to the ball peripheral in a fixed five-write burst.
//
// state  | meaning
// IDLE   | waiting for frame_tick
// UPDATE | advance/clamp position (if run)
// WR_R   | write radius       (addr 0)
// WR_XL  | write x[4:0]       (addr 3)
// WR_XH  | write x[9:5]       (addr 4, peripheral commits x)
// WR_YL  | write y[4:0]       (addr 5)
// WR_YH  | write y[9:5]       (addr 6, peripheral commits y)
module ball_motion_sequencer #(
  parameter int H_MAX  = 640,
  parameter int V_MAX  = 480,
  parameter int X_INIT = 30,
  parameter int Y_INIT = 30,
  parameter int R_INIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [3:0] speed_x,
  input  logic [3:0] speed_y,
  input  logic [7:0] radius,
  ball_motion_sequencer_if.master bus,
  output logic       busy,
  output logic       overrun,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UPDATE = 3'd1,
    WR_R   = 3'd2,
    WR_XL  = 3'd3,
    WR_XH  = 3'd4,
    WR_YL  = 3'd5,
    WR_YH  = 3'd6
  } state_t;

  localparam logic [9:0] H_MAX_W = 10'(H_MAX);
  localparam logic [9:0] V_MAX_W = 10'(V_MAX);
  localparam logic [7:0] R_SAT   = 8'(V_MAX / 2 - 1);

  state_t     state, state_next;
  logic       dir_x, dir_y;          // 1 = moving toward smaller coordinates
  logic [7:0] r_q;
  logic       overrun_q;
  logic [2:0] addr_q, addr_c;
  logic [7:0] data_q, data_c;
  logic       cs_c;
  logic [7:0] r_sat;
  logic [10:0] step_x, step_y;

  // Returns {dir, pos} after one step with the edge clamp applied. The clamp
  // is checked regardless of direction so a radius change pulls the ball in.
  function automatic logic [10:0] step_axis(
    input logic [9:0] pos,
    input logic       dir,
    input logic [3:0] spd,
    input logic [7:0] rr,
    input logic [9:0] max
  );
    logic signed [10:0] n;
    logic signed [10:0] hi;
    logic signed [10:0] lo;
    n  = dir ? ($signed({1'b0, pos}) - $signed({7'b0, spd}))
             : ($signed({1'b0, pos}) + $signed({7'b0, spd}));
    hi = $signed({1'b0, max}) - 11'sd1 - $signed({3'b0, rr});
    lo = $signed({3'b0, rr});
    if (n >= hi)      step_axis = {1'b1, 10'(hi)};
    else if (n <= lo) step_axis = {1'b0, 10'(lo)};
    else              step_axis = {dir, 10'(n)};
  endfunction

  assign r_sat  = (radius > R_SAT) ? R_SAT : radius;
  assign step_x = step_axis(pos_x, dir_x, speed_x, r_q, H_MAX_W);
  assign step_y = step_axis(pos_y, dir_y, speed_y, r_q, V_MAX_W);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: a tick is only accepted in IDLE; the burst is fixed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick) state_next = UPDATE;
      UPDATE:  state_next = WR_R;
      WR_R:    state_next = WR_XL;
      WR_XL:   state_next = WR_XH;
      WR_XH:   state_next = WR_YL;
      WR_YL:   state_next = WR_YH;
      WR_YH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: bus strobes per write state; address/data hold otherwise.
  always_comb begin
    cs_c   = 1'b0;
    addr_c = addr_q;
    data_c = data_q;
    case (state)
      WR_R:  begin cs_c = 1'b1; addr_c = 3'd0; data_c = r_q;                 end
      WR_XL: begin cs_c = 1'b1; addr_c = 3'd3; data_c = {3'b0, pos_x[4:0]}; end
      WR_XH: begin cs_c = 1'b1; addr_c = 3'd4; data_c = {3'b0, pos_x[9:5]}; end
      WR_YL: begin cs_c = 1'b1; addr_c = 3'd5; data_c = {3'b0, pos_y[4:0]}; end
      WR_YH: begin cs_c = 1'b1; addr_c = 3'd6; data_c = {3'b0, pos_y[9:5]}; end
      default: ;
    endcase
    bus.chipselect = cs_c;
    bus.write      = cs_c;
    bus.address    = addr_c;
    bus.writedata  = data_c;
    busy           = (state != IDLE);
    overrun        = overrun_q;
  end

  // Datapath: radius latch, position/direction update, sticky overrun and
  // the held copy of the last bus address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= 10'(X_INIT);
      pos_y     <= 10'(Y_INIT);
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      r_q       <= 8'(R_INIT);
      overrun_q <= 1'b0;
      addr_q    <= 3'd0;
      data_q    <= 8'd0;
    end else begin
      if (state == IDLE && frame_tick) r_q <= r_sat;
      if (state != IDLE && frame_tick) overrun_q <= 1'b1;
      if (state == UPDATE && run) begin
        dir_x <= step_x[10];
        pos_x <= step_x[9:0];
        dir_y <= step_y[10];
        pos_y <= step_y[9:0];
      end
      addr_q <= addr_c;
      data_q <= data_c;
    end
  end

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Scoreboard bench for ball_motion_sequencer: the driver runs a frame-level
// model of the ball and queues the expected writes; a monitor pops and
// compares them whenever the DUT strobes the bus.
module tb_ball_motion_sequencer;

  localparam int H_MAX = 640;
  localparam int V_MAX = 480;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       run;
  logic [3:0] speed_x, speed_y;
  logic [7:0] radius;
  logic       busy, overrun;
  logic [9:0] pos_x, pos_y;

  ball_motion_sequencer_if bus ();

  ball_motion_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .speed_x    (speed_x),
    .speed_y    (speed_y),
    .radius     (radius),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .pos_x      (pos_x),
    .pos_y      (pos_y)
  );

  always #10 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int px;
    int py;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  // Frame-level model state.
  int  m_px, m_py, m_dx, m_dy, m_r;
  int  cnt;      // edges remaining before the DUT is back in IDLE
  int  exp_ov;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_px = 30; m_py = 30; m_dx = 1; m_dy = 1; m_r = 16;
    cnt = 0; exp_ov = 0;
  endfunction

  task automatic move_axis(inout int p, inout int d, input int sp, input int mx);
    int n, hi;
    n  = p + d * sp;
    hi = mx - 1 - m_r;
    if (n >= hi) begin p = hi; d = -1; end
    else if (n <= m_r) begin p = m_r; d = 1; end
    else p = n;
  endtask

  task automatic model_accept();
    m_r = (radius > 239) ? 239 : int'(radius);
    if (run) begin
      move_axis(m_px, m_dx, int'(speed_x), H_MAX);
      move_axis(m_py, m_dy, int'(speed_y), V_MAX);
    end
    q.push_back('{0, m_r,       m_px, m_py});
    q.push_back('{3, m_px % 32, m_px, m_py});
    q.push_back('{4, m_px / 32, m_px, m_py});
    q.push_back('{5, m_py % 32, m_px, m_py});
    q.push_back('{6, m_py / 32, m_px, m_py});
  endtask

  // One clock: drive tick, let the model react to the same edge, check
  // status outputs just after the edge.
  task automatic step(input bit tk);
    frame_tick = tk;
    @(posedge clk);
    if (tk && cnt == 0) begin
      model_accept();
      cnt = 6;
    end else begin
      if (tk) exp_ov = 1;
      if (cnt > 0) cnt--;
    end
    #1;
    frame_tick = 1'b0;
    chk("busy", int'(busy), (cnt != 0) ? 1 : 0);
    chk("overrun", int'(overrun), exp_ov);
    if (cnt == 0) begin
      chk("pos_x_idle", int'(pos_x), m_px);
      chk("pos_y_idle", int'(pos_y), m_py);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("queue_empty", q.size(), 0);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.write || bus.chipselect) begin
        chk("cs_eq_write", int'(bus.chipselect), int'(bus.write));
        n_writes++;
        if (q.size() == 0) begin
          chk("unexpected_write_addr", int'(bus.address), -1);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", int'(bus.address), e.addr);
          chk("wr_data", int'(bus.writedata), e.data);
          chk("wr_pos_x", int'(pos_x), e.px);
          chk("wr_pos_y", int'(pos_y), e.py);
        end
      end
    end
  end

  initial begin
    int w0;
    frame_tick = 0; run = 1; speed_x = 2; speed_y = 3; radius = 16;
    reset = 1;
    model_reset();
    #35;
    reset = 0;

    // Idle after reset: outputs hold reset values, no writes.
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk("rst_addr", int'(bus.address), 0);
      chk("rst_data", int'(bus.writedata), 0);
      chk("rst_write", int'(bus.write), 0);
    end
    chk("rst_no_writes", n_writes, 0);

    // First tick from reset.
    step(1'b1);
    drain();
    chk("first_pos_x", int'(pos_x), 32);
    chk("first_pos_y", int'(pos_y), 33);
    chk("first_writes", n_writes, 5);

    // Tick at T+3 during a burst is dropped and sets overrun.
    w0 = n_writes;
    speed_x = 7; speed_y = 1;
    step(1'b1);
    step(1'b0); step(1'b0);
    step(1'b1);
    drain();
    chk("overrun_writes", n_writes - w0, 5);
    chk("overrun_sticky", int'(overrun), 1);

    // Hold position with run=0 while the radius saturates.
    run = 0; radius = 8'd255;
    step(1'b1);
    drain();
    run = 1; speed_y = 15;
    step(1'b1);
    drain();
    n_checks++;
    if (pos_y < 239 || pos_y > 240) begin
      n_fail++;
      $display("FAIL clamp_y: got %0d, expected 239..240", pos_y);
    end

    // Reset in the middle of a burst.
    radius = 20;
    w0 = n_writes;
    step(1'b1);
    step(1'b0); step(1'b0); step(1'b0);
    reset = 1;
    #1;
    chk("rst_mid_write", int'(bus.write), 0);
    chk("rst_mid_pos_x", int'(pos_x), 30);
    chk("rst_mid_pos_y", int'(pos_y), 30);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_overrun", int'(overrun), 0);
    q.delete();
    model_reset();
    @(negedge clk);
    reset = 0;
    chk("rst_mid_writes", n_writes - w0, 2);
    for (int i = 0; i < 6; i++) step(1'b0);
    chk("rst_mid_no_more", n_writes - w0, 2);

    // Randomized frames: speeds, radius and run change between bursts,
    // with occasional ticks landing inside a burst.
    for (int f = 0; f < 400; f++) begin
      if (cnt == 0) begin
        run     = ($urandom_range(0, 7) != 0);
        speed_x = 4'($urandom_range(0, 15));
        speed_y = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) radius = 8'($urandom_range(0, 255));
        else radius = 8'($urandom_range(4, 40));
      end
      step(1'b1);
      for (int k = 0; k < $urandom_range(5, 9); k++)
        step($urandom_range(0, 40) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
